// File: rtl/barrier_scheduler_if.sv
// rtl/barrier_scheduler_if.sv - game-side signal bundle between player/VGA logic and the barrier scheduler
interface barrier_scheduler_if;
    logic        i_v_sync;
    logic        i_start;
    logic [1:0]  i_player_lane;
    logic [2:0]  i_in_position;
    logic [2:0]  o_active;
    logic        o_hit;
    logic [15:0] o_score;
    logic [1:0]  o_lives;
    logic [1:0]  o_state;

    modport master (
        output i_v_sync, i_start, i_player_lane, i_in_position,
        input  o_active, o_hit, o_score, o_lives, o_state
    );

    modport slave (
        input  i_v_sync, i_start, i_player_lane, i_in_position,
        output o_active, o_hit, o_score, o_lives, o_state
    );
endinterface

// File: rtl/barrier_scheduler.sv
// rtl/barrier_scheduler.sv - three-lane barrier sequencer with score/lives; SCHED_SPEEDUP_EN shortens the spawn interval as score grows
module barrier_scheduler #(
    parameter int SPAWN_INTERVAL = 30,
    parameter int MAX_ACTIVE     = 2,
    parameter int HOLD_FRAMES    = 4,
    parameter int LIVES_INIT     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    barrier_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_PLAY = 2'd1,
        G_OVER = 2'd2
    } game_t;

    typedef enum logic [1:0] {
        L_FREE  = 2'd0,
        L_RUN   = 2'd1,
        L_ARMED = 2'd2
    } lane_t;

    localparam logic [1:0] MAX_BUSY  = 2'(MAX_ACTIVE);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_FRAMES - 1);
    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

    game_t       game_q, game_d;
    lane_t       lane_q [3];
    lane_t       lane_d [3];
    logic [3:0]  hold_q [3];
    logic [3:0]  hold_d [3];

    logic [2:0]  vs_pipe;
    logic        frame_tick;
    logic [2:0]  pos_meta, pos_sync, pos_prev;
    logic [2:0]  arm;
    logic [1:0]  player_q;

    logic [7:0]  lfsr_q, lfsr_next;
    logic [1:0]  pick_lane;
    logic [7:0]  spawn_cnt_q, cnt_inc;
    logic [7:0]  interval;
    logic [1:0]  busy;
    logic        play_tick, spawn_fire, start_go;

    logic [2:0]  judge, match;
    logic [1:0]  clear_cnt;
    logic [16:0] score_sum;
    logic [15:0] score_q;
    logic [1:0]  lives_q;
    logic        hit_q;

    // vsync: meta, sync, previous; tick is registered so it lands 3 clocks after the edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_pipe    <= '0;
            frame_tick <= 1'b0;
            pos_meta   <= '0;
            pos_sync   <= '0;
            pos_prev   <= '0;
            player_q   <= 2'd3;
        end else begin
            vs_pipe    <= {vs_pipe[1:0], bus.i_v_sync};
            frame_tick <= vs_pipe[1] & ~vs_pipe[2];
            pos_meta   <= bus.i_in_position;
            pos_sync   <= pos_meta;
            pos_prev   <= pos_sync;
            player_q   <= bus.i_player_lane;
        end
    end

    assign arm       = pos_sync & ~pos_prev;
    assign play_tick = frame_tick && (game_q == G_PLAY);
    assign start_go  = (game_q != G_PLAY) && bus.i_start;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign pick_lane = (lfsr_next[1:0] == 2'd3) ? 2'd1 : lfsr_next[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= 8'hA5;
        end else if (play_tick) begin
            lfsr_q <= lfsr_next;
        end
    end

`ifdef SCHED_SPEEDUP_EN
    logic [7:0]  interval_q;
    logic [16:0] speed_cut;
    logic [7:0]  interval_calc;

    assign speed_cut     = {3'b000, score_q[15:3], 1'b0};
    assign interval_calc = ((speed_cut + 17'd8) >= 17'(SPAWN_INTERVAL)) ? 8'd8
                         : 8'(SPAWN_INTERVAL) - speed_cut[7:0];
    assign interval      = interval_q;

    // new interval only takes hold when the counter restarts from zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            interval_q <= 8'(SPAWN_INTERVAL);
        end else if (start_go || spawn_fire) begin
            interval_q <= interval_calc;
        end
    end
`else
    assign interval = 8'(SPAWN_INTERVAL);
`endif

    always_comb begin
        busy = 2'd0;
        for (int n = 0; n < 3; n++) begin
            if (lane_q[n] != L_FREE) busy = busy + 2'd1;
        end
    end

    assign cnt_inc    = (spawn_cnt_q >= interval) ? interval : spawn_cnt_q + 8'd1;
    assign spawn_fire = play_tick && (cnt_inc == interval)
                     && (lane_q[pick_lane] == L_FREE) && (busy < MAX_BUSY);

    always_ff @(posedge i_clk) begin
        if (i_rst || start_go || spawn_fire) begin
            spawn_cnt_q <= 8'd0;
        end else if (play_tick) begin
            spawn_cnt_q <= cnt_inc;
        end
    end

    // each barrier is judged once, on its RUN->ARMED transition
    always_comb begin
        judge     = '0;
        match     = '0;
        clear_cnt = 2'd0;
        for (int n = 0; n < 3; n++) begin
            judge[n] = arm[n] && (lane_q[n] == L_RUN) && (game_q == G_PLAY);
            match[n] = judge[n] && (player_q == 2'(n));
            if (judge[n] && !match[n]) clear_cnt = clear_cnt + 2'd1;
        end
    end

    assign score_sum = {1'b0, score_q} + {15'b0, clear_cnt};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            score_q <= 16'd0;
            lives_q <= LIVES_RST;
            hit_q   <= 1'b0;
        end else begin
            hit_q <= |match;
            if (start_go) begin
                score_q <= 16'd0;
                lives_q <= LIVES_RST;
            end else begin
                score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                if ((|match) && (lives_q != 2'd0)) lives_q <= lives_q - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            game_q <= G_IDLE;
        end else begin
            game_q <= game_d;
        end
    end

    always_comb begin
        game_d = game_q;
        case (game_q)
            G_IDLE:  if (bus.i_start) game_d = G_PLAY;
            G_PLAY:  if (lives_q == 2'd0) game_d = G_OVER;
            G_OVER:  if (bus.i_start) game_d = G_PLAY;
            default: game_d = G_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 3; n++) begin
            if (i_rst) begin
                lane_q[n] <= L_FREE;
                hold_q[n] <= 4'd0;
            end else begin
                lane_q[n] <= lane_d[n];
                hold_q[n] <= hold_d[n];
            end
        end
    end

    // lanes only move while the game stays in PLAY; leaving PLAY sweeps them all back to FREE
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            lane_d[n] = lane_q[n];
            hold_d[n] = hold_q[n];
            if (game_d != G_PLAY) begin
                lane_d[n] = L_FREE;
                hold_d[n] = 4'd0;
            end else begin
                case (lane_q[n])
                    L_FREE: begin
                        if (spawn_fire && (pick_lane == 2'(n))) lane_d[n] = L_RUN;
                    end
                    L_RUN: begin
                        if (judge[n]) begin
                            lane_d[n] = L_ARMED;
                            hold_d[n] = 4'd0;
                        end
                    end
                    L_ARMED: begin
                        if (play_tick) begin
                            if (hold_q[n] == HOLD_LAST) begin
                                lane_d[n] = L_FREE;
                                hold_d[n] = 4'd0;
                            end else begin
                                hold_d[n] = hold_q[n] + 4'd1;
                            end
                        end
                    end
                    default: lane_d[n] = L_FREE;
                endcase
            end
        end
    end

    always_comb begin
        bus.o_active = '0;
        for (int n = 0; n < 3; n++) begin
            bus.o_active[n] = (lane_q[n] != L_FREE);
        end
    end

    assign bus.o_hit   = hit_q;
    assign bus.o_score = score_q;
    assign bus.o_lives = lives_q;
    assign bus.o_state = game_q;

endmodule
